// File: rtl/sdram_pkg.sv
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared constants and types for sdram_bus clients.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

    localparam int SDRAM_ADDR_BITS = 22;
    localparam int SDRAM_DATA_BITS = 16;

    // Write mask value meaning "no byte lanes"; reads hold wm here.
    localparam logic [1:0] WM_NONE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_FINISH   = 3'd3,
        ST_ABORTING = 3'd4
    } reader_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_bus.sv
// ============================================================================
//  Module      : sdram_bus
//  Description : Toggle-handshake single-word channel to the SDRAM
//                controller. A request is pending while req != ack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_bus;
    import sdram_pkg::*;

    logic                        req;
    logic                        ack;
    logic                        we;
    logic [1:0]                  wm;
    logic [SDRAM_ADDR_BITS-1:0]  address;
    logic [SDRAM_DATA_BITS-1:0]  data_write;
    logic [SDRAM_DATA_BITS-1:0]  data_read;

    // Initiator side (the client driving requests).
    modport controller (
        output req, address, data_write, we, wm,
        input  ack, data_read
    );

    // Memory-controller side.
    modport memory (
        input  req, address, data_write, we, wm,
        output ack, data_read
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with simultaneous push/pop and flush.
//                Head word is read straight from the storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; flush wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/sdram_stream_reader.sv
// ============================================================================
//  Module      : sdram_stream_reader
//  Description : Turns a "read N words from address A" command into a series
//                of single-word toggle-handshake reads on sdram_bus, buffers
//                the returned words in a prefetch FIFO and streams them out
//                over valid/ready. One request outstanding at most.
//  Options     : SDRAM_STREAM_READER_CHECKSUM_EN adds a 16-bit XOR checksum
//                output over every streamed word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_stream_reader
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS  = SDRAM_ADDR_BITS,
    parameter int LEN_BITS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [LEN_BITS-1:0]  length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SDRAM_STREAM_READER_CHECKSUM_EN
    output logic [15:0]          checksum,
`endif
    sdram_bus.controller         mem
);

    localparam int                c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W:0]  c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    reader_state_t        r_state;
    reader_state_t        w_next_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [LEN_BITS-1:0]  r_remaining;
    logic                 r_req;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_ack_match;
    logic                 w_inflight;
    logic                 w_credit;
    logic [c_CNT_W:0]     w_occupancy;
    logic                 w_accept;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_done_set;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;

    assign w_ack_match = (mem.ack == r_req);
    assign w_inflight  = ~w_ack_match;
    // Words in the FIFO plus the one possibly on the way must leave a free
    // slot, so a returning word always has somewhere to land.
    assign w_occupancy = {1'b0, w_fifo_count} + {{c_CNT_W{1'b0}}, w_inflight};
    assign w_credit    = (w_occupancy < c_DEPTH) & ~w_fifo_full;
    assign w_pop       = ~w_fifo_empty & out_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_ISSUE;
                    end else begin
                        w_done_set   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    w_flush      = 1'b1;
                    w_next_state = ST_ABORTING;
                end else if (w_credit) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    w_flush      = 1'b1;
                    w_next_state = ST_ABORTING;
                end else if (w_ack_match) begin
                    w_push       = 1'b1;
                    w_next_state = (r_remaining == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_FINISH: begin
                if (abort) begin
                    w_flush      = 1'b1;
                    w_next_state = ST_ABORTING;
                end else if (w_fifo_empty) begin
                    w_done_set   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_ABORTING: begin
                // Keep the FIFO clear while the last pending word drains.
                w_flush = 1'b1;
                if (w_ack_match) begin
                    w_done_set   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command datapath: address/length tracking, request toggle, status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_remaining <= '0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_accept) begin
                r_addr      <= start_addr;
                r_remaining <= length;
                r_busy      <= 1'b1;
            end
            if (w_issue) begin
                // The bus address is a separate register so it stays frozen
                // for the whole pending request while r_addr moves ahead.
                r_mem_addr  <= r_addr;
                r_req       <= ~r_req;
                r_addr      <= r_addr + ADDR_BITS'(1);
                r_remaining <= r_remaining - LEN_BITS'(1);
            end
            if (w_done_set) begin
                r_busy <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_push      (w_push),
        .i_push_data (mem.data_read),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (out_data),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

`ifdef SDRAM_STREAM_READER_CHECKSUM_EN
    logic [15:0] r_checksum;
    logic        r_ck_frozen;

    // XOR of every streamed word; frozen from the cycle abort is seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum  <= '0;
            r_ck_frozen <= 1'b0;
        end else if (w_accept) begin
            r_checksum  <= '0;
            r_ck_frozen <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            r_ck_frozen <= 1'b1;
        end else if (w_pop && !r_ck_frozen) begin
            r_checksum  <= r_checksum ^ out_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign mem.req        = r_req;
    assign mem.address    = SDRAM_ADDR_BITS'(r_mem_addr);
    assign mem.we         = 1'b0;
    assign mem.wm         = WM_NONE;
    assign mem.data_write = '0;

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = ~w_fifo_empty;

endmodule

`default_nettype wire

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Initiator-side client of sdram_bus. Converts a "read N words from address A" command into a sequence of toggle-handshake single-word reads.
- Buffers the returned words in a small prefetch FIFO and presents them as a valid/ready stream.
- Sits between the SDRAM controller channel and consumers such as PPU/PRG loaders or DMA that need linear reads.
- At most one request is outstanding on the bus at any time.

Parameters:
- ADDR_BITS, 22, width of sdram_bus address ({bank, column, row} packed).
- LEN_BITS, 16, width of the word-count command field.
- FIFO_DEPTH, 4, prefetch FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle command strobe; ignored while busy=1.
- start_addr  input  ADDR_BITS  first word address.
- length  input  LEN_BITS  number of 16-bit words; 0 means no-op.
- abort  input  1  cancel the current command; level-sampled.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse when a command completes or an abort finishes.
- out_data  output  16  stream word (FIFO head).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- mem  sdram_bus.controller  -  drives req, address, data_write, we, wm; samples ack, data_read.

Behaviour:
- Reset values: mem.req=0, mem.we=0, mem.wm=2'b11, mem.data_write=0, mem.address=0, busy=0, done=0, out_valid=0, FIFO empty, state=IDLE.
  - The controller must be reset in the same domain so that ack also returns to 0.
- Bus protocol: a request is pending while req != ack. The reader issues a request by driving address, then toggling req in the same cycle.
  - Completion is the first cycle in which ack == req. data_read is valid in that cycle and is pushed into the FIFO in that cycle.
  - address must not change while a request is pending. we is always 0; wm is don't-care on reads and is held at 2'b11.
- Credit rule: a request may be issued only when fifo_count + inflight < FIFO_DEPTH. This guarantees a returning word is never dropped.
- State machine:
  - IDLE:
    - start & length!=0: latch addr=start_addr, remaining=length; busy<=1; go to ISSUE.
    - start & length==0: done pulses next cycle; busy stays 0.
  - ISSUE:
    - If credit is available: toggle req; addr<=addr+1 (modulo 2^ADDR_BITS, flat increment of the packed value); remaining<=remaining-1; go to WAIT.
    - Otherwise stay in ISSUE.
  - WAIT:
    - On ack==req: push data_read.
    - If remaining==0, go to FINISH; otherwise go to ISSUE. The earliest next toggle is the cycle after the push.
  - FINISH: wait until the FIFO is empty, pulse done, busy<=0, go to IDLE. Words still in the FIFO are drained by the consumer before done.
  - ABORTING (entered from ISSUE/WAIT/FINISH when abort=1):
    - Issue no new requests.
    - If a request is in flight, wait for ack and discard its data.
    - Then flush the FIFO: out_valid drops the cycle after entry. Pulse done, go to IDLE.
    - abort in IDLE has no effect.
- FIFO:
  - push and pop in the same cycle are both honoured and the count is unchanged.
  - A pop with the FIFO empty is ignored.
  - out_data is registered head data; out_valid reflects count!=0.
- Throughput: one word per round trip. Request-to-ack latency is set by the controller (for a read, about 6 cycles plus arbitration). The reader adds 1 cycle between ack and the next toggle.
- start while busy is ignored, with no error indication.

Optional Feature:
- SDRAM_STREAM_READER_CHECKSUM_EN defined:
  - Adds output checksum[15:0], reset 0 and cleared on each accepted start.
  - checksum <= checksum ^ out_data on every out_valid & out_ready transfer.
  - On abort it is frozen at its value when abort was sampled.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sdram_pkg:
  - SDRAM_ADDR_BITS (22) and SDRAM_DATA_BITS (16).
  - Reader state enum type (IDLE, ISSUE, WAIT, FINISH, ABORTING).
  - WM_NONE=2'b11 constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/count/empty/full, async active-low reset) holds the prefetch buffer.
- Credit and state logic stay in sdram_stream_reader.

Test Plan:
- start_addr=22'h000100, length=4, out_ready=1, memory model returning data=addr[15:0] -> stream 0x0100,0x0101,0x0102,0x0103; done pulses once; busy falls with done; req toggles exactly 4 times.
- length=10, FIFO_DEPTH=4, out_ready=0 until FIFO full -> at most 4 requests issued and no further toggle; after out_ready=1 all 10 words arrive in order with none lost.
- start_addr=22'h3FFFFE, length=3 -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000 presented on mem.address.
- abort asserted 2 cycles after the 2nd req toggle (ack pending), length=8 -> no new toggle; pending ack absorbed; out_valid=0 the cycle after entering ABORTING; done pulses; a following start (addr 0x40, length 1) delivers 0x0040.
- start with length=0 -> done pulses the next cycle, busy stays 0, req unchanged; start asserted while busy -> ignored.
- reset_n asserted low mid-command with a request pending -> req=0, busy=0, out_valid=0 immediately (async); after release with the controller also reset, a new command of length 2 completes normally.
